// File: rtl/imem_pipe_param.sv
// Loadable instruction memory with a one-cycle registered fetch port.
// A program is streamed in through the load port; fetches are served once the final word arrives.
module imem_pipe_param #(
    parameter int unsigned          DATA_W   = 20,
    parameter int unsigned          ADDR_W   = 20,
    parameter int unsigned          DEPTH    = 16,
    parameter logic [DATA_W-1:0]    NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    output logic              addr_err,
    output logic              ready,
    output logic [ADDR_W:0]   load_cnt
);

    localparam int unsigned    IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic load_in_range;
    logic load_acc;
    logic pc_in_range;

    // Extra top bit lets DEPTH == 2**ADDR_W compare without wrapping.
    assign load_in_range = {1'b0, load_addr} < DEPTH_L;
    assign pc_in_range   = {1'b0, pc_in} < DEPTH_L;
    assign load_acc      = load_en && (state != RUN) && load_in_range;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY:   if (load_en) state_nxt = load_last ? RUN : LOAD;
            LOAD:    if (load_en && load_last) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = EMPTY;
        endcase
    end

    // Output logic
    always_comb begin
        ready = (state == RUN);
    end

    // Storage is not reset; the rst_n gate blocks a write on an edge sampled during reset.
    always_ff @(posedge clk) begin
        if (load_acc && rst_n) mem[load_addr[IDX_W-1:0]] <= load_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        load_cnt <= '0;
        else if (load_acc && load_cnt != DEPTH_L) load_cnt <= load_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_out   <= NOP_WORD;
            instr_valid <= 1'b0;
            addr_err    <= 1'b0;
        end else if (!ready || flush) begin
            instr_out   <= NOP_WORD;
            instr_valid <= 1'b0;
            addr_err    <= 1'b0;
        end else if (stall) begin
            instr_out   <= instr_out;
            instr_valid <= instr_valid;
            addr_err    <= addr_err;
        end else if (fetch_en) begin
            instr_out   <= pc_in_range ? mem[pc_in[IDX_W-1:0]] : NOP_WORD;
            instr_valid <= 1'b1;
            addr_err    <= !pc_in_range;
        end else begin
            instr_out   <= NOP_WORD;
            instr_valid <= 1'b0;
            addr_err    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imem_pipe_param.sv
// Directed bench for imem_pipe_param: load, fetch, stall/flush priority, range errors, reset abort.
module tb_imem_pipe_param;

    localparam int unsigned DATA_W = 20;
    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DEPTH  = 16;

    logic              clk;
    logic              rst_n;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              fetch_en;
    logic [ADDR_W-1:0] pc_in;
    logic              stall;
    logic              flush;
    logic [DATA_W-1:0] instr_out;
    logic              instr_valid;
    logic              addr_err;
    logic              ready;
    logic [ADDR_W:0]   load_cnt;

    int unsigned checks;
    int unsigned errors;

    logic [DATA_W-1:0] words [4];

    imem_pipe_param #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .NOP_WORD ('0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_last   (load_last),
        .fetch_en    (fetch_en),
        .pc_in       (pc_in),
        .stall       (stall),
        .flush       (flush),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .addr_err    (addr_err),
        .ready       (ready),
        .load_cnt    (load_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are then driven and outputs sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        load_en = 1'b0; load_last = 1'b0; load_addr = '0; load_data = '0;
        fetch_en = 1'b0; pc_in = '0; stall = 1'b0; flush = 1'b0;
    endtask

    task automatic do_load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic last);
        load_en = 1'b1; load_addr = a; load_data = d; load_last = last;
        step();
        load_en = 1'b0; load_last = 1'b0;
    endtask

    task automatic do_fetch(input logic [ADDR_W-1:0] pc);
        fetch_en = 1'b1; pc_in = pc;
        step();
        fetch_en = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        words[0] = 20'h1040A;
        words[1] = 20'h04C02;
        words[2] = 20'h05283;
        words[3] = 20'h00501;

        idle();
        rst_n = 1'b0;
        #2;
        check("rst_instr",  32'(instr_out),   32'h0);
        check("rst_valid",  32'(instr_valid), 32'h0);
        check("rst_err",    32'(addr_err),    32'h0);
        check("rst_ready",  32'(ready),       32'h0);
        check("rst_cnt",    32'(load_cnt),    32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // First load word with a fetch attempt alongside: not ready yet.
        fetch_en = 1'b1; pc_in = '0;
        do_load(20'd0, words[0], 1'b0);
        fetch_en = 1'b0;
        check("preload_ready", 32'(ready),       32'h0);
        check("preload_valid", 32'(instr_valid), 32'h0);
        check("preload_cnt",   32'(load_cnt),    32'd1);

        do_load(20'd1, words[1], 1'b0);
        do_load(20'd2, words[2], 1'b0);
        do_load(20'd20, 20'hABCDE, 1'b0);
        check("oor_load_cnt", 32'(load_cnt), 32'd3);
        check("oor_load_rdy", 32'(ready),    32'h0);
        do_load(20'd3, words[3], 1'b1);
        check("load_ready", 32'(ready),    32'h1);
        check("load_cnt4",  32'(load_cnt), 32'd4);

        for (int i = 0; i < 4; i++) begin
            do_fetch(ADDR_W'(i));
            check("fetch_instr", 32'(instr_out),   32'(words[i]));
            check("fetch_valid", 32'(instr_valid), 32'h1);
            check("fetch_err",   32'(addr_err),    32'h0);
        end

        do_fetch(20'd16);
        check("pc16_instr", 32'(instr_out),   32'h0);
        check("pc16_valid", 32'(instr_valid), 32'h1);
        check("pc16_err",   32'(addr_err),    32'h1);

        // Error flag held through a stall.
        stall = 1'b1; fetch_en = 1'b1; pc_in = 20'd1;
        step();
        stall = 1'b0; fetch_en = 1'b0;
        check("stall_err_hold", 32'(addr_err), 32'h1);

        do_fetch(20'd1);
        check("pc1_instr", 32'(instr_out), 32'h04C02);
        check("pc1_err",   32'(addr_err),  32'h0);

        // High PC bit beyond the index width must not alias to word 0.
        do_fetch(20'h10000);
        check("pc_hi_instr", 32'(instr_out), 32'h0);
        check("pc_hi_err",   32'(addr_err),  32'h1);

        step();
        check("idle_instr", 32'(instr_out),   32'h0);
        check("idle_valid", 32'(instr_valid), 32'h0);
        check("idle_err",   32'(addr_err),    32'h0);

        do_fetch(20'd2);
        check("pc2_instr", 32'(instr_out), 32'h05283);
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1; fetch_en = 1'b1; pc_in = ADDR_W'(i == 2 ? 3 : i);
            step();
            check("stall_instr", 32'(instr_out),   32'h05283);
            check("stall_valid", 32'(instr_valid), 32'h1);
        end

        stall = 1'b1; flush = 1'b1; fetch_en = 1'b1; pc_in = 20'd0;
        step();
        idle();
        check("flush_instr", 32'(instr_out),   32'h0);
        check("flush_valid", 32'(instr_valid), 32'h0);

        do_load(20'd0, 20'hFFFFF, 1'b1);
        check("run_load_cnt", 32'(load_cnt), 32'd4);
        do_fetch(20'd0);
        check("run_load_mem", 32'(instr_out), 32'h1040A);

        // Asynchronous reset between edges.
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_instr", 32'(instr_out),   32'h0);
        check("arst_valid", 32'(instr_valid), 32'h0);
        check("arst_ready", 32'(ready),       32'h0);
        check("arst_cnt",   32'(load_cnt),    32'h0);
        step();
        rst_n = 1'b1;
        do_fetch(20'd0);
        check("post_rst_ready", 32'(ready),       32'h0);
        check("post_rst_valid", 32'(instr_valid), 32'h0);
        do_load(20'd5, 20'h12345, 1'b1);
        check("reload_ready", 32'(ready),    32'h1);
        check("reload_cnt",   32'(load_cnt), 32'd1);
        do_fetch(20'd5);
        check("reload_instr", 32'(instr_out),   32'h12345);
        check("reload_valid", 32'(instr_valid), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
